alu_result_serializer: RTL and testbench

- Downstream stage of the 16-bit ALU. Captures each registered ALU result (2*DATA_WIDTH bits, qualified by the ALU valid pulse) into a small synchronous FIFO.
- Drains the FIFO as two bytes, low byte first then high byte, to the UART transmitter parallel-data port using a valid/busy handshake.
- Decouples single-cycle ALU bursts from the slow UART TX frame rate.

---
 rtl/alu_result_serializer_pkg.sv | 15 +
 rtl/result_fifo.sv | 68 ++++++
 rtl/alu_result_serializer.sv | 100 ++++++++++
 tb/tb_alu_result_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_serializer_pkg.sv
// Shared constants and serializer FSM encoding for the ALU -> UART result path.
package alu_result_serializer_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefFifoDepth = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSendLo = 3'd1,
    StWaitLo = 3'd2,
    StSendHi = 3'd3,
    StWaitHi = 3'd4
  } ser_state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with registered full flag; same-edge read and write allowed when full.
module result_fifo
  import alu_result_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DefDataWidth,
  parameter int unsigned DEPTH = DefFifoDepth
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q;
  logic             do_wr, do_rd;

  assign do_rd = rd_en && (count_q != '0);
  // A write into a full FIFO is only legal when it frees a slot on the same edge.
  assign do_wr = wr_en && ((count_q != CntW'(DEPTH)) || do_rd);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CntW'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = (count_q == '0);

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and sends each as two bytes (low first) over a valid/busy handshake.
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_data_valid,
  output logic                    fifo_full,
  output logic                    overflow
);

  localparam int unsigned WordW = 2 * DATA_WIDTH;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  ser_state_e       state_q;
  logic [WordW-1:0] hold_q;
  logic [WordW-1:0] fifo_rd_data;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  assign pop  = (state_q == StIdle) && !fifo_empty;
  assign drop = alu_out_vld && (fifo_count == CntW'(FIFO_DEPTH)) && !pop;

  result_fifo #(
    .WIDTH (WordW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (alu_out_vld),
    .wr_data (alu_out),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            hold_q        <= fifo_rd_data;
            tx_p_data     <= fifo_rd_data[DATA_WIDTH-1:0];
            tx_data_valid <= 1'b1;
            state_q       <= StSendLo;
          end
        end
        StSendLo: begin
          if (tx_busy) begin
            tx_data_valid <= 1'b0;
            state_q       <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (!tx_busy) begin
            tx_p_data     <= hold_q[WordW-1:DATA_WIDTH];
            tx_data_valid <= 1'b1;
            state_q       <= StSendHi;
          end
        end
        StSendHi: begin
          if (tx_busy) begin
            tx_data_valid <= 1'b0;
            state_q       <= StWaitHi;
          end
        end
        StWaitHi: begin
          // Returning through idle leaves a one-cycle gap before the next pop.
          if (!tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer with a queue-based byte-stream model.
module tb_alu_result_serializer;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic [15:0] alu_out;
  logic        alu_out_vld;
  logic        tx_busy;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        fifo_full;
  logic        overflow;

  logic busy_auto, busy_man, auto_mode;
  assign tx_busy = auto_mode ? busy_auto : busy_man;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_wq[$];
  logic [7:0]  m_cur[$];
  bit          m_pres, m_wait, m_ovf;

  logic [7:0]  dut_bytes[$];
  logic [7:0]  exp_q[$];

  alu_result_serializer #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_out       (alu_out),
    .alu_out_vld   (alu_out_vld),
    .tx_busy       (tx_busy),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .fifo_full     (fifo_full),
    .overflow      (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words queue up, each goes out as low byte then high byte; a byte is
  // taken when busy is seen while it is presented, and the next byte (or word)
  // waits for busy to fall. A new word is only fetched from a fully idle link.
  initial begin
    bit          pop;
    logic [15:0] w;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_wq.delete();
        m_cur.delete();
        m_pres = 1'b0;
        m_wait = 1'b0;
        m_ovf  = 1'b0;
      end else begin
        pop = !m_pres && !m_wait && (m_cur.size() == 0) && (m_wq.size() > 0);
        if (pop) begin
          w = m_wq.pop_front();
          m_cur.push_back(w[7:0]);
          m_cur.push_back(w[15:8]);
          m_pres = 1'b1;
        end else if (m_pres && tx_busy) begin
          m_pres = 1'b0;
          void'(m_cur.pop_front());
          m_wait = 1'b1;
        end else if (m_wait && !tx_busy) begin
          m_wait = 1'b0;
          m_pres = (m_cur.size() > 0);
        end
        if (alu_out_vld) begin
          if (m_wq.size() < D) m_wq.push_back(alu_out);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        check("tx_data_valid", {31'd0, tx_data_valid}, {31'd0, m_pres});
        if (m_pres) check("tx_p_data", {24'd0, tx_p_data}, {24'd0, m_cur[0]});
        check("fifo_full", {31'd0, fifo_full}, {31'd0, (m_wq.size() == D)});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      end
    end
  end

  // Byte log: the half cycle before acceptance shows valid and busy together.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_data_valid && tx_busy) dut_bytes.push_back(tx_p_data);
    end
  end

  // Simple UART stand-in: busy one cycle after valid, held for ten cycles.
  initial begin
    int cnt;
    cnt = 0;
    busy_auto = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!auto_mode || rst) begin
        busy_auto = 1'b0;
        cnt = 0;
      end else if (busy_auto) begin
        if (cnt >= 10) begin
          busy_auto = 1'b0;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else if (tx_data_valid) begin
        busy_auto = 1'b1;
        cnt = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    alu_out = w;
    alu_out_vld = 1'b1;
    step();
    alu_out_vld = 1'b0;
  endtask

  task automatic do_reset();
    auto_mode = 1'b0;
    busy_man = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dut_bytes.delete();
    step();
  endtask

  task automatic wait_bytes(input int n, input int limit);
    for (int i = 0; i < limit && dut_bytes.size() < n; i++) step();
    repeat (15) step();
    check("byte_count", dut_bytes.size(), n);
  endtask

  task automatic compare_bytes(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < dut_bytes.size()) check(name, {24'd0, dut_bytes[i]}, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    alu_out = '0;
    alu_out_vld = 1'b0;
    busy_man = 1'b0;
    auto_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();
    check("rst_tx_p_data", {24'd0, tx_p_data}, 32'h0);
    check("rst_tx_data_valid", {31'd0, tx_data_valid}, 32'h0);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'h0);
    check("rst_overflow", {31'd0, overflow}, 32'h0);

    // Single result 0x1234.
    auto_mode = 1'b1;
    push(16'h1234);
    wait_bytes(2, 200);
    exp_q = {8'h34, 8'h12};
    compare_bytes("t1_bytes");
    check("t1_valid_idle", {31'd0, tx_data_valid}, 32'h0);
    check("t1_full_idle", {31'd0, fifo_full}, 32'h0);

    // Burst of six while UART busy: fifth fills, sixth is dropped.
    do_reset();
    busy_man = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      alu_out = 16'(i);
      alu_out_vld = 1'b1;
      step();
      if (i == 5) begin
        check("t2_full_after_5", {31'd0, fifo_full}, 32'h1);
        check("t2_no_overflow", {31'd0, overflow}, 32'h0);
      end
      if (i == 6) check("t3_overflow_set", {31'd0, overflow}, 32'h1);
    end
    alu_out_vld = 1'b0;
    auto_mode = 1'b1;
    wait_bytes(10, 800);
    exp_q = {8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
    compare_bytes("t3_bytes");
    check("t3_overflow_sticky", {31'd0, overflow}, 32'h1);

    // Full FIFO, push on the same edge as the pop from idle.
    do_reset();
    busy_man = 1'b1;
    for (int i = 1; i <= 5; i++) push(16'(i));
    busy_man = 1'b0;
    step();
    busy_man = 1'b1;
    step();
    busy_man = 1'b0;
    step();
    push(16'hBEEF);
    check("t4_full_after_swap", {31'd0, fifo_full}, 32'h1);
    check("t4_no_overflow", {31'd0, overflow}, 32'h0);
    auto_mode = 1'b1;
    wait_bytes(12, 800);
    exp_q = {8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00,
             8'hEF, 8'hBE};
    compare_bytes("t4_bytes");

    // Reset while the high byte of 0xA55A is presented.
    do_reset();
    auto_mode = 1'b1;
    push(16'hA55A);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (tx_data_valid && tx_p_data == 8'hA5) found = 1'b1;
    end
    check("t5_hi_presented", {31'd0, found}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_valid", {31'd0, tx_data_valid}, 32'h0);
    check("t5_async_data", {24'd0, tx_p_data}, 32'h0);
    check("t5_async_full", {31'd0, fifo_full}, 32'h0);
    check("t5_async_ovf", {31'd0, overflow}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dut_bytes.delete();
    step();
    push(16'h00FF);
    wait_bytes(2, 200);
    exp_q = {8'hFF, 8'h00};
    compare_bytes("t5_bytes");

    // UART never accepts: low byte stays presented.
    do_reset();
    push(16'h1111);
    repeat (100) step();
    check("t6_valid_held", {31'd0, tx_data_valid}, 32'h1);
    check("t6_data_held", {24'd0, tx_p_data}, 32'h11);
    check("t6_no_bytes", dut_bytes.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
